palette_ram: RTL and testbench

- Writable, parametrised palette store for the PPU. Replaces the fixed 4x4 colour table.
- Holds NUM_PAL palettes of 4 colours each. The CPU bus writes it at run time.
- Serves two independent lookup channels, background and sprite, with registered outputs.
- Applies a frame-timed global brightness fade engine to both channels. Sits between the tile/sprite pixel pipelines and the VGA output mux.

---
 rtl/palette_ram_pkg.sv | 28 ++
 rtl/palette_ram_fade_ctrl.sv | 87 ++++++++
 rtl/palette_ram.sv | 105 ++++++++++
 tb/tb_palette_ram.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_ram_pkg.sv
// Shared PPU definitions for the palette store: colour widths, fade FSM states
// and the saturating per-channel fade subtract.
package palette_ram_pkg;

  localparam int CH_BIT  = 4;
  localparam int RGB_BIT = 3 * CH_BIT;

  typedef enum logic {
    IDLE   = 1'b0,
    FADING = 1'b1
  } fade_state_e;

  // Each of R, G, B is darkened by level and clamps at zero instead of wrapping.
  function automatic logic [RGB_BIT-1:0] sat_sub_rgb(
    input logic [RGB_BIT-1:0] color,
    input logic [CH_BIT-1:0]  level
  );
    logic [RGB_BIT-1:0] res;
    logic [CH_BIT-1:0]  ch;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      ch = color[i*CH_BIT +: CH_BIT];
      res[i*CH_BIT +: CH_BIT] = (ch > level) ? (ch - level) : '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/palette_ram_fade_ctrl.sv
// Frame-timed global brightness fade: walks fade_level one step toward the
// latched target every FADE_PERIOD frame ticks.
module palette_fade_ctrl
  import palette_ram_pkg::*;
#(
  parameter int FADE_PERIOD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              fade_start,
  input  logic [CH_BIT-1:0] fade_target,
  output logic [CH_BIT-1:0] fade_level,
  output logic              fade_busy
);

  localparam int CNT_W = (FADE_PERIOD > 1) ? $clog2(FADE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_PERIOD - 1);

  fade_state_e       r_state;
  fade_state_e       w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CH_BIT-1:0] r_level;
  logic [CH_BIT-1:0] w_level_nxt;
  logic [CH_BIT-1:0] r_target;
  logic [CH_BIT-1:0] w_target_nxt;
  logic [CH_BIT-1:0] w_level_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_level  <= '0;
      r_target <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_level  <= w_level_nxt;
      r_target <= w_target_nxt;
    end
  end

  // A new fade_start always wins; any tick arriving with it is dropped.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_level_nxt  = r_level;
    w_target_nxt = r_target;
    w_level_step = (r_target > r_level) ? (r_level + 1'b1) : (r_level - 1'b1);
    case (r_state)
      IDLE: begin
        if (fade_start) begin
          w_target_nxt = fade_target;
          w_cnt_nxt    = '0;
          if (fade_target != r_level) begin
            w_state_nxt = FADING;
          end
        end
      end
      FADING: begin
        if (fade_start) begin
          w_target_nxt = fade_target;
          w_cnt_nxt    = '0;
          w_state_nxt  = (fade_target != r_level) ? FADING : IDLE;
        end else if (frame_tick) begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_level_nxt = w_level_step;
            if (w_level_step == r_target) begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fade_level = r_level;
    fade_busy  = (r_state == FADING);
  end

endmodule

// File: rtl/palette_ram.sv
// Writable PPU palette store with independent background and sprite lookup
// channels, both darkened by the shared fade engine.
module palette_ram
  import palette_ram_pkg::*;
#(
  parameter  int NUM_PAL     = 8,
  parameter  int FADE_PERIOD = 4,
  localparam int PAL_W       = $clog2(NUM_PAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [PAL_W+1:0]   wr_addr,
  input  logic [RGB_BIT-1:0] wr_data,
  input  logic               bg_valid,
  input  logic [PAL_W-1:0]   bg_pal,
  input  logic [1:0]         bg_idx,
  input  logic               spr_valid,
  input  logic [PAL_W-1:0]   spr_pal,
  input  logic [1:0]         spr_idx,
  input  logic               frame_tick,
  input  logic               fade_start,
  input  logic [CH_BIT-1:0]  fade_target,
  output logic [RGB_BIT-1:0] bg_color,
  output logic               bg_color_valid,
  output logic [RGB_BIT-1:0] spr_color,
  output logic               spr_color_valid,
  output logic               spr_transparent,
  output logic [CH_BIT-1:0]  fade_level,
  output logic               fade_busy
);

  localparam int NUM_ENT = NUM_PAL * 4;

  logic [RGB_BIT-1:0] r_mem [NUM_ENT];
  logic [RGB_BIT-1:0] r_bg_color;
  logic               r_bg_valid;
  logic [RGB_BIT-1:0] r_spr_color;
  logic               r_spr_valid;
  logic               r_spr_transp;

  logic [PAL_W+1:0]   w_bg_addr;
  logic [PAL_W+1:0]   w_spr_addr;
  logic [RGB_BIT-1:0] w_bg_faded;
  logic [RGB_BIT-1:0] w_spr_faded;
  logic [CH_BIT-1:0]  w_fade_level;
  logic               w_fade_busy;

  palette_fade_ctrl #(
    .FADE_PERIOD (FADE_PERIOD)
  ) u_fade (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .fade_start  (fade_start),
    .fade_target (fade_target),
    .fade_level  (w_fade_level),
    .fade_busy   (w_fade_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Reads see the array before this edge's write lands, giving old data on a collision.
  assign w_bg_addr   = {bg_pal, bg_idx};
  assign w_spr_addr  = {spr_pal, spr_idx};
  assign w_bg_faded  = sat_sub_rgb(r_mem[w_bg_addr], w_fade_level);
  assign w_spr_faded = sat_sub_rgb(r_mem[w_spr_addr], w_fade_level);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bg_color   <= '0;
      r_bg_valid   <= 1'b0;
      r_spr_color  <= '0;
      r_spr_valid  <= 1'b0;
      r_spr_transp <= 1'b0;
    end else begin
      r_bg_valid  <= bg_valid;
      r_spr_valid <= spr_valid;
      if (bg_valid) begin
        r_bg_color <= w_bg_faded;
      end
      if (spr_valid) begin
        r_spr_color  <= w_spr_faded;
        r_spr_transp <= (spr_idx == 2'd0);
      end
    end
  end

  assign bg_color        = r_bg_color;
  assign bg_color_valid  = r_bg_valid;
  assign spr_color       = r_spr_color;
  assign spr_color_valid = r_spr_valid;
  assign spr_transparent = r_spr_transp;
  assign fade_level      = w_fade_level;
  assign fade_busy       = w_fade_busy;

endmodule

// File: tb/tb_palette_ram.sv
// Scoreboard bench for palette_ram: stimulus pushes per-cycle expectations from
// a behavioural model; a monitor pops and compares after every rising edge.
module tb_palette_ram;

  localparam int NUM_PAL     = 8;
  localparam int FADE_PERIOD = 4;
  localparam int NUM_ENT     = NUM_PAL * 4;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [11:0] wr_data;
  logic        bg_valid;
  logic [2:0]  bg_pal;
  logic [1:0]  bg_idx;
  logic        spr_valid;
  logic [2:0]  spr_pal;
  logic [1:0]  spr_idx;
  logic        frame_tick;
  logic        fade_start;
  logic [3:0]  fade_target;
  logic [11:0] bg_color;
  logic        bg_color_valid;
  logic [11:0] spr_color;
  logic        spr_color_valid;
  logic        spr_transparent;
  logic [3:0]  fade_level;
  logic        fade_busy;

  palette_ram #(
    .NUM_PAL     (NUM_PAL),
    .FADE_PERIOD (FADE_PERIOD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .bg_valid        (bg_valid),
    .bg_pal          (bg_pal),
    .bg_idx          (bg_idx),
    .spr_valid       (spr_valid),
    .spr_pal         (spr_pal),
    .spr_idx         (spr_idx),
    .frame_tick      (frame_tick),
    .fade_start      (fade_start),
    .fade_target     (fade_target),
    .bg_color        (bg_color),
    .bg_color_valid  (bg_color_valid),
    .spr_color       (spr_color),
    .spr_color_valid (spr_color_valid),
    .spr_transparent (spr_transparent),
    .fade_level      (fade_level),
    .fade_busy       (fade_busy)
  );

  typedef struct packed {
    logic        wrEn;
    logic [4:0]  wrAddr;
    logic [11:0] wrData;
    logic        bgValid;
    logic [2:0]  bgPal;
    logic [1:0]  bgIdx;
    logic        sprValid;
    logic [2:0]  sprPal;
    logic [1:0]  sprIdx;
    logic        frameTick;
    logic        fadeStart;
    logic [3:0]  fadeTarget;
  } stim_t;

  typedef struct packed {
    logic        bgValid;
    logic [11:0] bgColor;
    logic        sprValid;
    logic [11:0] sprColor;
    logic        sprTransp;
    logic [3:0]  fadeLevel;
    logic        fadeBusy;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sbQ[$];
  exp_t lastExp;

  int mMem[NUM_ENT];
  int mLevel;
  int mTarget;
  int mTicks;
  bit mBusy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int fadeColor(int c, int lvl);
    int r, g, b;
    r = (c >> 8) & 15;
    g = (c >> 4) & 15;
    b = c & 15;
    r = (r > lvl) ? r - lvl : 0;
    g = (g > lvl) ? g - lvl : 0;
    b = (b > lvl) ? b - lvl : 0;
    return (r << 8) | (g << 4) | b;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NUM_ENT; i++) mMem[i] = 0;
    mLevel  = 0;
    mTarget = 0;
    mTicks  = 0;
    mBusy   = 1'b0;
    lastExp = '0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic driveIdle();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    bg_valid = 0; bg_pal = 0; bg_idx = 0;
    spr_valid = 0; spr_pal = 0; spr_idx = 0;
    frame_tick = 0; fade_start = 0; fade_target = 0;
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the next edge.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(negedge clk);
    wr_en = s.wrEn; wr_addr = s.wrAddr; wr_data = s.wrData;
    bg_valid = s.bgValid; bg_pal = s.bgPal; bg_idx = s.bgIdx;
    spr_valid = s.sprValid; spr_pal = s.sprPal; spr_idx = s.sprIdx;
    frame_tick = s.frameTick; fade_start = s.fadeStart; fade_target = s.fadeTarget;
    e = lastExp;
    e.bgValid  = s.bgValid;
    e.sprValid = s.sprValid;
    if (s.bgValid) e.bgColor = 12'(fadeColor(mMem[{s.bgPal, s.bgIdx}], mLevel));
    if (s.sprValid) begin
      e.sprColor  = 12'(fadeColor(mMem[{s.sprPal, s.sprIdx}], mLevel));
      e.sprTransp = (s.sprIdx == 2'd0);
    end
    if (s.wrEn) mMem[s.wrAddr] = int'(s.wrData);
    if (s.fadeStart) begin
      mTarget = int'(s.fadeTarget);
      mTicks  = 0;
      mBusy   = (mTarget != mLevel);
    end else if (mBusy && s.frameTick) begin
      mTicks++;
      if (mTicks == FADE_PERIOD) begin
        mTicks = 0;
        mLevel = (mTarget > mLevel) ? mLevel + 1 : mLevel - 1;
        if (mLevel == mTarget) mBusy = 1'b0;
      end
    end
    e.fadeLevel = 4'(mLevel);
    e.fadeBusy  = mBusy;
    lastExp = e;
    sbQ.push_back(e);
  endtask

  task automatic idleCycle();
    applyStimulus('0);
  endtask

  task automatic writeEntry(input int addr, input int data);
    stim_t s = '0;
    s.wrEn = 1; s.wrAddr = 5'(addr); s.wrData = 12'(data);
    applyStimulus(s);
  endtask

  task automatic lookBoth(input int bgA, input int sprA);
    stim_t s = '0;
    s.bgValid = 1; s.bgPal = 3'(bgA >> 2); s.bgIdx = 2'(bgA);
    s.sprValid = 1; s.sprPal = 3'(sprA >> 2); s.sprIdx = 2'(sprA);
    applyStimulus(s);
  endtask

  task automatic tickCycle();
    stim_t s = '0;
    s.frameTick = 1;
    applyStimulus(s);
  endtask

  task automatic startFade(input int tgt, input bit withTick);
    stim_t s = '0;
    s.fadeStart = 1; s.fadeTarget = 4'(tgt); s.frameTick = withTick;
    applyStimulus(s);
  endtask

  task automatic checkResetState();
    checkOutput("rst bg_color", bg_color, 0);
    checkOutput("rst bg_color_valid", bg_color_valid, 0);
    checkOutput("rst spr_color", spr_color, 0);
    checkOutput("rst spr_color_valid", spr_color_valid, 0);
    checkOutput("rst spr_transparent", spr_transparent, 0);
    checkOutput("rst fade_level", fade_level, 0);
    checkOutput("rst fade_busy", fade_busy, 0);
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("bg_color_valid", bg_color_valid, e.bgValid);
        checkOutput("bg_color", bg_color, e.bgColor);
        checkOutput("spr_color_valid", spr_color_valid, e.sprValid);
        checkOutput("spr_color", spr_color, e.sprColor);
        if (e.sprValid) checkOutput("spr_transparent", spr_transparent, e.sprTransp);
        checkOutput("fade_level", fade_level, e.fadeLevel);
        checkOutput("fade_busy", fade_busy, e.fadeBusy);
      end
    end
  end

  initial begin
    stim_t s;
    int guard;
    rst = 1'b1;
    driveIdle();
    modelReset();
    #12;
    checkResetState();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] write/lookup basics");
    writeEntry(5, 'hA5F);
    lookBoth(5, 5);
    for (int a = 0; a < NUM_ENT; a++) lookBoth(a, NUM_ENT - 1 - a);

    $display("[TB] read-before-write collision");
    s = '0;
    s.wrEn = 1; s.wrAddr = 5'd5; s.wrData = 12'h123;
    s.sprValid = 1; s.sprPal = 3'd1; s.sprIdx = 2'd1;
    applyStimulus(s);
    lookBoth(5, 5);

    $display("[TB] sprite transparency");
    writeEntry(8, 'hFFF);
    lookBoth(0, 8);
    lookBoth(0, 11);
    idleCycle();

    $display("[TB] fade to level 3");
    writeEntry(9, 'h2F5);
    startFade(3, 0);
    for (int t = 0; t < 12; t++) begin
      tickCycle();
      lookBoth(9, 8);
    end
    lookBoth(9, 9);

    $display("[TB] retarget coincident with tick");
    startFade(2, 0);
    for (int t = 0; t < 4; t++) tickCycle();
    startFade(0, 1);
    for (int t = 0; t < 8; t++) begin
      tickCycle();
      idleCycle();
    end
    lookBoth(9, 5);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 500; n++) begin
      s = '0;
      s.wrEn       = ($urandom_range(0, 3) == 0);
      s.wrAddr     = 5'($urandom_range(0, NUM_ENT - 1));
      s.wrData     = 12'($urandom_range(0, 4095));
      s.bgValid    = 1'($urandom_range(0, 1));
      s.bgPal      = 3'($urandom_range(0, NUM_PAL - 1));
      s.bgIdx      = 2'($urandom_range(0, 3));
      s.sprValid   = 1'($urandom_range(0, 1));
      s.sprPal     = 3'($urandom_range(0, NUM_PAL - 1));
      s.sprIdx     = 2'($urandom_range(0, 3));
      s.frameTick  = ($urandom_range(0, 2) == 0);
      s.fadeStart  = ($urandom_range(0, 39) == 0);
      s.fadeTarget = 4'($urandom_range(0, 15));
      applyStimulus(s);
    end

    $display("[TB] reset during fade");
    startFade(0, 0);
    guard = 0;
    while (mBusy && guard < 200) begin
      tickCycle();
      guard++;
    end
    writeEntry(3, 'h7E1);
    writeEntry(20, 'hC3A);
    startFade(5, 0);
    for (int t = 0; t < 11; t++) tickCycle();
    #2;
    rst = 1'b1;
    #1;
    checkResetState();
    sbQ.delete();
    modelReset();
    driveIdle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    startFade(0, 0);
    for (int a = 0; a < NUM_ENT; a++) lookBoth(a, a);
    idleCycle();
    idleCycle();
    @(posedge clk);
    #3;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
